// File: rtl/com_pkg.sv
// rtl/com_pkg.sv - shared constants, state encoding and command whitelist for the command-frame parser
package com_pkg;

    localparam logic [7:0] CMD_DRIVE_1 = 8'h01;
    localparam logic [7:0] CMD_DRIVE_2 = 8'h02;
    localparam logic [7:0] CMD_DRIVE_3 = 8'h03;
    localparam logic [7:0] CMD_DRIVE_4 = 8'h04;
    localparam logic [7:0] CMD_STEER_1 = 8'h11;
    localparam logic [7:0] CMD_STEER_2 = 8'h12;
    localparam logic [7:0] CMD_STEER_3 = 8'h13;
    localparam logic [7:0] CMD_STEER_4 = 8'h14;
    localparam logic [7:0] CMD_51      = 8'h51;
    localparam logic [7:0] CMD_52      = 8'h52;
    localparam logic [7:0] CMD_61      = 8'h61;
    localparam logic [7:0] CMD_62      = 8'h62;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_CSUM    = 2'd1;
    localparam logic [1:0] ERR_CMD     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE    = 3'b001,
        S_PAYLOAD = 3'b010,
        S_CHECK   = 3'b100
    } state_t;

    function automatic logic is_valid_cmd(input logic [7:0] cmd);
        case (cmd)
            CMD_DRIVE_1, CMD_DRIVE_2, CMD_DRIVE_3, CMD_DRIVE_4,
            CMD_STEER_1, CMD_STEER_2, CMD_STEER_3, CMD_STEER_4,
            CMD_51, CMD_52, CMD_61, CMD_62: is_valid_cmd = 1'b1;
            default:                        is_valid_cmd = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/com_timeout_counter.sv
// rtl/com_timeout_counter.sv - inter-byte idle counter; expired marks the last allowed idle cycle
module com_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic reload,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst || reload || !run) begin
            count_q <= '0;
        end else if (count_q != LAST) begin
            count_q <= count_q + 1'b1;
        end
    end

    // A byte on the expiry cycle reloads instead, so it always wins.
    assign expired = run && !reload && (count_q == LAST);

endmodule

// File: rtl/com_frame_parser.sv
// rtl/com_frame_parser.sv - assembles command/payload/checksum frames from the UART byte stream
module com_frame_parser #(
    parameter int PAYLOAD_BYTES  = 3,
    parameter int CHECKSUM_EN    = 1,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 data_in,
    input  logic                       data_valid,
    output logic [7:0]                 cmd_out,
    output logic [8*PAYLOAD_BYTES-1:0] payload_out,
    output logic                       frame_valid,
    output logic                       frame_err,
    output logic [1:0]                 err_code,
    output logic                       busy
);

    import com_pkg::*;

    localparam int PW    = 8 * PAYLOAD_BYTES;
    localparam int IDX_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAYLOAD_BYTES - 1);

    state_t           state_q, state_d;
    logic [7:0]       cmd_sh, xor_q;
    logic [PW-1:0]    pay_sh, pay_next;
    logic [IDX_W-1:0] idx_q;
    logic             fin, csum_bad, timeout, expired;
    logic             frame_ok, frame_bad;

    com_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .run     (state_q != S_IDLE),
        .reload  (data_valid),
        .expired (expired)
    );

    always_comb begin
        state_d  = state_q;
        fin      = 1'b0;
        csum_bad = 1'b0;
        timeout  = 1'b0;
        pay_next = pay_sh;
        case (state_q)
            S_IDLE: begin
                if (data_valid) state_d = S_PAYLOAD;
            end
            S_PAYLOAD: begin
                if (data_valid) begin
                    for (int k = 0; k < PAYLOAD_BYTES; k++) begin
                        if (idx_q == IDX_W'(k)) pay_next[8*k +: 8] = data_in;
                    end
                    if (idx_q == IDX_LAST) begin
                        if (CHECKSUM_EN != 0) begin
                            state_d = S_CHECK;
                        end else begin
                            fin     = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                end else if (expired) begin
                    timeout = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_CHECK: begin
                if (data_valid) begin
                    fin      = 1'b1;
                    csum_bad = (data_in != xor_q);
                    state_d  = S_IDLE;
                end else if (expired) begin
                    timeout = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign frame_ok  = fin && !csum_bad && is_valid_cmd(cmd_sh);
    assign frame_bad = fin && !frame_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cmd_sh      <= '0;
            xor_q       <= '0;
            pay_sh      <= '0;
            idx_q       <= '0;
            cmd_out     <= '0;
            payload_out <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            err_code    <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            frame_valid <= frame_ok;
            frame_err   <= frame_bad || timeout;
            if (frame_bad) begin
                err_code <= csum_bad ? ERR_CSUM : ERR_CMD;
            end else if (timeout) begin
                err_code <= ERR_TIMEOUT;
            end
            // pay_next already holds the final byte when there is no checksum.
            if (frame_ok) begin
                cmd_out     <= cmd_sh;
                payload_out <= pay_next;
            end
            if (data_valid) begin
                case (state_q)
                    S_IDLE: begin
                        cmd_sh <= data_in;
                        xor_q  <= data_in;
                        idx_q  <= '0;
                    end
                    S_PAYLOAD: begin
                        pay_sh <= pay_next;
                        xor_q  <= xor_q ^ data_in;
                        idx_q  <= idx_q + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy = (state_q != S_IDLE);

endmodule

// File: doc/com_frame_parser.md
# com_frame_parser

Parametrised command-frame receiver for the vehicle's serial command link. Consumes the byte stream from the UART receiver, one byte per `data_valid` strobe. Assembles frames of one command byte, `PAYLOAD_BYTES` payload bytes and an optional XOR checksum byte. Validated frames are presented to the motion/steering control logic as a command plus a packed payload with a one-cycle `frame_valid` pulse. Malformed, unknown or stalled frames are rejected with an error code.

## Interface
- `PAYLOAD_BYTES`, 3, payload bytes per frame (1..8)
- `CHECKSUM_EN`, 1, 1 = frame carries a trailing checksum byte; 0 = no checksum
- `TIMEOUT_CYCLES`, 50000, maximum idle clocks between bytes inside a frame (≥2)
- `clk` input 1 system clock
- `rst` input 1 reset; one clock; reset is synchronous and active-high
- `data_in` input 8 received byte
- `data_valid` input 1 one-cycle strobe; `data_in` is valid this cycle
- `cmd_out` output 8 command of last good frame
- `payload_out` output 8*PAYLOAD_BYTES payload of last good frame
- `frame_valid` output 1 one-cycle pulse; new `cmd_out`/`payload_out` are valid
- `frame_err` output 1 one-cycle pulse; frame rejected
- `err_code` output 2 reason for the rejection, valid with `frame_err` (0 none, 1 checksum, 2 unknown command, 3 timeout)
- `busy` output 1 high while a frame is partially received

## Operation
- **States.**
  - IDLE: the next accepted byte is the command.
  - PAYLOAD: collects payload bytes.
  - CHECK: waits for the checksum byte (only when `CHECKSUM_EN` = 1).
- **IDLE.** On `data_valid`, latch the command, seed the running XOR with it, clear the byte index, and go to PAYLOAD.
- **PAYLOAD.** Byte k (0-based) is written to the shadow payload bits [8k+7:8k]; the first payload byte is the LSB. XOR the byte into the checksum. After byte `PAYLOAD_BYTES-1`, go to CHECK if `CHECKSUM_EN`, otherwise finalise.
- **CHECK.** The byte received must equal the running XOR; then finalise.
- **Finalise.**
  - Checksum mismatch gives err 1.
  - Otherwise, a command not in the whitelist gives err 2.
  - Otherwise, copy the shadow registers to `cmd_out`/`payload_out` and pulse `frame_valid`.
  - Checksum error takes priority over unknown command.
  - In every case, return to IDLE.
- **Command whitelist:** 0x01–0x04 (drive), 0x11–0x14 (steer), 0x51, 0x52, 0x61, 0x62.
- **Rejected frames.** `cmd_out`/`payload_out` keep the last good frame; they never show partial data.
- **Timeout.** The counter runs whenever the state is not IDLE and reloads on every accepted byte. When `TIMEOUT_CYCLES` clocks pass with no byte, pulse `frame_err` with err 3, discard the frame, and return to IDLE.
- **Byte vs. timeout.** If `data_valid` arrives on the expiry cycle, the byte wins and no timeout is raised.
- `busy` = (state != IDLE).

## Timing
- **Reset values:** `cmd_out` = 0, `payload_out` = 0, `frame_valid` = 0, `frame_err` = 0, `err_code` = 0, `busy` = 0, state IDLE, counters 0.
- **Reset mid-frame:** the partial frame is silently discarded, with no error pulse.
- **Latency.** `frame_valid` or `frame_err` is asserted the clock after the final byte's `data_valid` edge. `cmd_out`/`payload_out` update on the same edge that `frame_valid` rises.
- **Error code timing.** `err_code` is registered and held until the next `frame_err`; it is cleared by reset only.
- **Back-to-back frames.** A byte arriving on the cycle that `frame_valid`/`frame_err` is high is accepted as the next command byte.
- **Byte rate.** `data_valid` may be high on consecutive cycles; one byte is accepted per cycle with no stall path.
- **Timeout boundary.** Exactly `TIMEOUT_CYCLES` idle clocks after the last accepted byte, `frame_err` pulses on the following edge.
- `frame_valid` and `frame_err` are never high together.

## Structure
- **Shared package `com_pkg`:**
  - command constants (CMD_DRIVE_*, CMD_STEER_*, CMD_5x, CMD_6x);
  - error-code constants ERR_NONE, ERR_CSUM, ERR_CMD, ERR_TIMEOUT;
  - state encoding (one-hot IDLE/PAYLOAD/CHECK);
  - whitelist function `is_valid_cmd(byte)`.
- **Sub-module `com_timeout_counter`** (parameter `TIMEOUT_CYCLES`):
  - inputs `clk`, `rst`, `run`, `reload`;
  - output `expired` (one-cycle pulse);
  - width `$clog2(TIMEOUT_CYCLES+1)`.
- **Parser datapath:** byte index counter of width `$clog2(PAYLOAD_BYTES)`, 8-bit XOR accumulator, shadow payload register.

## Test plan
- Defaults; send 0x01, 0xAA, 0xBB, 0xCC, then checksum 0x01^0xAA^0xBB^0xCC = 0xDC → one `frame_valid` pulse; `cmd_out` = 0x01; `payload_out` = 0xCCBBAA.
- Same frame with checksum 0x00 → `frame_err` with `err_code` = 1; outputs keep their previous values.
- Command 0x7F with a correct checksum → `frame_err` with `err_code` = 2; send 0x7F with a bad checksum → `err_code` = 1.
- Send 0x11, 0x05, then silence for `TIMEOUT_CYCLES` (=100 in the bench) → `frame_err` with `err_code` = 3 and `busy` low. Repeat with the next byte on the expiry cycle → no error, frame continues.
- `CHECKSUM_EN` = 0, `PAYLOAD_BYTES` = 2; bytes 0x62, 0x34, 0x12 on consecutive cycles, immediately followed by 0x51, 0x00, 0x01 → two `frame_valid` pulses with payloads 0x1234 and 0x0100.
- Assert `rst` after the second byte of a frame, then send a full valid frame → no error pulse; the new frame is decoded correctly.
